// File: rtl/lsu_mem_interface_if.sv
// Data-bus bundle between the LSU memory stage (master) and the data memory (slave).
// Carries the req/gnt/rvalid handshake plus address, byte enables and data.
interface lsu_mem_interface_if;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_interface.sv
// LSU memory stage: one outstanding load/store over a req/gnt/rvalid bus with timeout.
// Optional MISALIGNED_TRAP_EN rejects misaligned half/word accesses at accept time.
module lsu_mem_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    input  logic                       req_read,
    input  logic [3:0]                 req_we,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [2:0]                 req_op,
    input  logic [4:0]                 req_rd,
    output logic                       req_ready,
    output logic                       stall,
    lsu_mem_interface_if.master        mem,
    output logic                       wb_valid,
    output logic                       wb_we,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic                       bus_error,
    output logic                       misaligned
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
    typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_e;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            we_q, we_d;
    op_e                   op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic                  read_q, read_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_we_q, wb_we_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  bus_error_q, bus_error_d;
    logic                  misaligned_q, misaligned_d;
    logic                  trap_req;
    logic                  timeout_hit;

    function automatic logic [31:0] align_load(input op_e op, input logic [1:0] lane,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   align_load = {{24{b[7]}}, b};
            OP_LBU:  align_load = {24'h0, b};
            OP_LH:   align_load = {{16{h[15]}}, h};
            OP_LHU:  align_load = {16'h0, h};
            OP_LW:   align_load = rdata;
            default: align_load = '0;
        endcase
    endfunction

`ifdef MISALIGNED_TRAP_EN
    always_comb begin
        case (op_e'(req_op))
            OP_LH, OP_LHU, OP_SH: trap_req = req_addr[0];
            OP_LW, OP_SW:         trap_req = (req_addr[1:0] != 2'b00);
            default:              trap_req = 1'b0;
        endcase
    end
`else
    assign trap_req = 1'b0;
`endif

    // Counter saturates so a disabled timeout never wraps into a false hit.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_LIM);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        op_d         = op_q;
        rd_d         = rd_q;
        read_d       = read_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = '0;
        wb_data_d    = '0;
        bus_error_d  = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (trap_req) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        we_d    = req_we;
                        op_d    = op_e'(req_op);
                        rd_d    = req_rd;
                        read_d  = req_read;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                end else if (mem.mem_gnt) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                // Completion is checked first so a response on the terminal cycle still retires.
                if (mem.mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = read_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = read_q ? align_load(op_q, addr_q[1:0], mem.mem_rdata) : '0;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= '0;
            op_q         <= OP_LB;
            rd_q         <= '0;
            read_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            bus_error_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            read_q       <= read_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            bus_error_q  <= bus_error_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign stall         = !req_ready;
    assign mem.mem_req   = (state_q == ADDR);
    assign mem.mem_we    = (state_q == ADDR) ? we_q : '0;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_we         = wb_we_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign bus_error     = bus_error_q;
    assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Self-checking bench for lsu_mem_interface: directed table, corner sequences and
// randomized transactions against a behavioural load/store model.
module tb_lsu_mem_interface;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_read;
    logic [3:0]  req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        req_ready, stall;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_error, misaligned;

    int unsigned checks = 0;
    int unsigned errors = 0;

    lsu_mem_interface_if bus ();

    lsu_mem_interface #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_read(req_read), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op), .req_rd(req_rd),
        .req_ready(req_ready), .stall(stall), .mem(bus.master),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_error(bus_error), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // Behavioural model: extract the addressed field arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned sh8 = 8 * int'(addr[1:0]);
        int unsigned sh16 = 16 * int'(addr[1]);
        logic [31:0] b = (rdata >> sh8) & 32'hFF;
        logic [31:0] h = (rdata >> sh16) & 32'hFFFF;
        case (op)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            LW:      return rdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] model_we(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            SB:      return 4'b0001 << addr[1:0];
            SH:      return addr[1] ? 4'b1100 : 4'b0011;
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit model_trap(input logic [2:0] op, input logic [31:0] addr);
`ifdef MISALIGNED_TRAP_EN
        if ((op == LH || op == LHU || op == SH) && addr[0]) return 1'b1;
        if ((op == LW || op == SW) && addr[1:0] != 2'b00) return 1'b1;
        return 1'b0;
`else
        return (op == 3'd0) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Drives one request from an IDLE cycle and follows it to writeback (or trap).
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input int unsigned gd, input int unsigned rvd,
                           input logic [31:0] exp_data, input string tag);
        logic       is_read = (op < 3'd5);
        logic [3:0] we = model_we(op, addr);
        bit         trap = model_trap(op, addr);
        chk1({tag, ".ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_read = is_read; req_we = we; req_addr = addr;
        req_wdata = wdata; req_op = op; req_rd = rd;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_op = 3'($urandom); req_rd = 5'($urandom); req_we = 4'($urandom);
        if (trap) begin
            chk1({tag, ".mis"}, misaligned, 1'b1);
            chk1({tag, ".mreq_trap"}, bus.mem_req, 1'b0);
            chk1({tag, ".ready_trap"}, req_ready, 1'b1);
            step();
            chk1({tag, ".mis_end"}, misaligned, 1'b0);
            chk1({tag, ".mreq_trap2"}, bus.mem_req, 1'b0);
            chk1({tag, ".wbv_trap"}, wb_valid, 1'b0);
            return;
        end
        chk1({tag, ".mis0"}, misaligned, 1'b0);
        for (int unsigned i = 0; i <= gd; i++) begin
            chk1({tag, ".mreq"}, bus.mem_req, 1'b1);
            chk1({tag, ".stall_a"}, stall, 1'b1);
            chk({tag, ".maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
            chk({tag, ".mwe"}, 32'(bus.mem_we), 32'(we));
            chk({tag, ".mwdata"}, bus.mem_wdata, wdata);
            chk1({tag, ".wbv_a"}, wb_valid, 1'b0);
            bus.mem_gnt    = (i == gd);
            bus.mem_rvalid = (i != gd);
            bus.mem_rdata  = $urandom;
            step();
        end
        bus.mem_gnt = 1'b0;
        for (int unsigned j = 0; j <= rvd; j++) begin
            chk1({tag, ".mreq_d"}, bus.mem_req, 1'b0);
            chk({tag, ".mwe_d"}, 32'(bus.mem_we), 32'h0);
            chk1({tag, ".stall_d"}, stall, 1'b1);
            chk1({tag, ".wbv_d"}, wb_valid, 1'b0);
            chk1({tag, ".berr_d"}, bus_error, 1'b0);
            bus.mem_rvalid = (j == rvd);
            bus.mem_rdata  = (j == rvd) ? rdata : 32'($urandom);
            step();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        chk1({tag, ".wbv"}, wb_valid, 1'b1);
        chk1({tag, ".wbwe"}, wb_we, is_read);
        chk({tag, ".wbrd"}, 32'(wb_rd), 32'(rd));
        chk({tag, ".wbdata"}, wb_data, exp_data);
        chk1({tag, ".ready_wb"}, req_ready, 1'b1);
        chk1({tag, ".berr"}, bus_error, 1'b0);
    endtask

    task automatic run_timeout(input bit give_gnt, input string tag);
        req_valid = 1'b1; req_read = 1'b1; req_we = 4'b0000; req_addr = 32'h300;
        req_op = LW; req_rd = 5'd7;
        step();
        req_valid = 1'b0;
        for (int unsigned k = 1; k <= 16; k++) begin
            chk1({tag, ".berr_early"}, bus_error, 1'b0);
            chk1({tag, ".stall"}, stall, 1'b1);
            chk1({tag, ".wbv"}, wb_valid, 1'b0);
            bus.mem_gnt    = give_gnt && (k == 1);
            bus.mem_rvalid = 1'b0;
            step();
        end
        bus.mem_gnt = 1'b0;
        chk1({tag, ".berr"}, bus_error, 1'b1);
        chk1({tag, ".ready"}, req_ready, 1'b1);
        chk1({tag, ".wbv_end"}, wb_valid, 1'b0);
        chk1({tag, ".mreq_end"}, bus.mem_req, 1'b0);
        step();
        chk1({tag, ".berr_pulse"}, bus_error, 1'b0);
        chk1({tag, ".ready2"}, req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{LB,  32'h103, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1]  = '{LHU, 32'h102, 32'h8001_1234, 32'h0000_8001};
        vecs[2]  = '{LH,  32'h102, 32'h8001_1234, 32'hFFFF_8001};
        vecs[3]  = '{LBU, 32'h101, 32'h0000_9A00, 32'h0000_009A};
        vecs[4]  = '{LB,  32'h100, 32'h1234_567F, 32'h0000_007F};
        vecs[5]  = '{LH,  32'h100, 32'hABCD_7FFF, 32'h0000_7FFF};
        vecs[6]  = '{LHU, 32'h200, 32'h1234_F00D, 32'h0000_F00D};
        vecs[7]  = '{LW,  32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[8]  = '{LB,  32'h102, 32'h00C3_0000, 32'hFFFF_FFC3};
        vecs[9]  = '{SB,  32'h203, 32'h5A5A_5A5A, 32'h0000_0000};
        vecs[10] = '{SH,  32'h202, 32'hFFFF_FFFF, 32'h0000_0000};

        reset_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_we = '0;
        req_addr = '0; req_wdata = '0; req_op = '0; req_rd = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step(); step();
        chk1("rst.ready", req_ready, 1'b1);
        chk1("rst.stall", stall, 1'b0);
        chk1("rst.mreq", bus.mem_req, 1'b0);
        chk("rst.mwe", 32'(bus.mem_we), 32'h0);
        chk("rst.maddr", bus.mem_addr, 32'h0);
        chk1("rst.wbv", wb_valid, 1'b0);
        chk("rst.wbdata", wb_data, 32'h0);
        chk1("rst.berr", bus_error, 1'b0);
        chk1("rst.mis", misaligned, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++)
            run_txn(vecs[i].op, vecs[i].addr, 32'h1122_3344 + 32'(i), vecs[i].rdata,
                    5'(i + 1), 0, 0, vecs[i].exp_data, $sformatf("vec%0d", i));

        run_txn(SW, 32'h200, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd3, 3, 0, 32'h0, "sw_gnt3");
        run_txn(LW, 32'h108, 32'h0, 32'h7654_3210, 5'd9, 7, 7, 32'h7654_3210, "terminal");
        step();
        chk1("idle.wbv", wb_valid, 1'b0);

        run_timeout(1'b1, "to_data");
        run_timeout(1'b0, "to_addr");

`ifdef MISALIGNED_TRAP_EN
        run_txn(LW, 32'h101, 32'h0, 32'h5566_7788, 5'd4, 0, 0, 32'h0, "lw_mis");
`else
        run_txn(LW, 32'h101, 32'h0, 32'h5566_7788, 5'd4, 0, 0, 32'h5566_7788, "lw_mis");
`endif
        step();

        // Reset while waiting for the response; a late rvalid must be ignored.
        req_valid = 1'b1; req_read = 1'b1; req_we = 4'b0000; req_addr = 32'h400;
        req_op = LW; req_rd = 5'd12;
        step();
        req_valid = 1'b0;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        chk1("rstd.in_data", stall, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("rstd.ready", req_ready, 1'b1);
        chk1("rstd.stall", stall, 1'b0);
        chk1("rstd.mreq", bus.mem_req, 1'b0);
        chk("rstd.maddr", bus.mem_addr, 32'h0);
        chk1("rstd.wbv", wb_valid, 1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFACE_FACE;
        step(); step();
        reset_n = 1'b1;
        step();
        chk1("rstd.wbv_after", wb_valid, 1'b0);
        chk1("rstd.ready_after", req_ready, 1'b1);
        step();
        chk1("rstd.wbv_after2", wb_valid, 1'b0);
        bus.mem_rvalid = 1'b0;
        step();

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op    = 3'($urandom_range(0, 7));
            logic [31:0] addr  = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] rdata = $urandom;
            logic [4:0]  rd    = 5'($urandom);
            int unsigned gd    = $urandom_range(0, 6);
            int unsigned rvd   = $urandom_range(0, 6);
            int unsigned gap   = $urandom_range(0, 2);
            logic [31:0] exp   = (op < 3'd5) ? model_load(op, addr, rdata) : 32'h0;
            run_txn(op, addr, wdata, rdata, rd, gd, rvd, exp, $sformatf("rnd%0d", n));
            for (int unsigned g = 0; g < gap; g++) begin
                step();
                chk1("rnd.idle_mreq", bus.mem_req, 1'b0);
                chk1("rnd.idle_ready", req_ready, 1'b1);
                chk1("rnd.idle_wbv", wb_valid, 1'b0);
            end
        end
        step();
        chk1("end.wbv", wb_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_interface.md
Name: lsu_mem_interface

Overview:
Data-memory access stage downstream of the execute-stage load/store unit. Latches one load/store request (address, byte-enables, write data, op), runs a req/gnt/rvalid handshake on the data bus with a configurable timeout, then returns aligned, sign/zero-extended load data to writeback. Holds the pipeline (stall) while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in ADDR+DATA before bus_error; 0 disables timeout
CNT_WIDTH, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present from execute
req_read  in  1  1=load, 0=store
req_we  in  4  byte write enables (0000 for loads)
req_addr  in  32  effective byte address
req_wdata  in  32  lane-replicated store data
req_op  in  op_type  OP0 LB, OP1 LBU, OP2 LH, OP3 LHU, OP4 LW, OP5 SB, OP6 SH, OP7 SW
req_rd  in  5  destination register
req_ready  out  1  request accepted when req_valid & req_ready
stall  out  1  transaction outstanding; freezes upstream
mem_req  out  1  bus request
mem_we  out  4  bus byte enables
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  bus write data
mem_gnt  in  1  bus accepted request
mem_rvalid  in  1  response (load data or store ack)
mem_rdata  in  32  bus read data
wb_valid  out  1  one-cycle writeback pulse
wb_we  out  1  register-bank write enable (1 loads, 0 stores)
wb_rd  out  5  destination register
wb_data  out  32  aligned load result
bus_error  out  1  one-cycle timeout pulse
misaligned  out  1  one-cycle misaligned pulse (see optional feature)

Behaviour:
- Async reset (reset_n=0): state IDLE, counter 0, every output 0 except req_ready=1. Reset mid-transaction abandons it; later mem_rvalid is ignored.
- FSM IDLE/ADDR/DATA. req_ready = (state==IDLE); stall = !req_ready.
- IDLE: on req_valid, register req_*; next ADDR. mem_req=0.
- ADDR: mem_req=1, mem_we/mem_addr/mem_wdata held stable from registers until mem_gnt. On mem_gnt -> DATA. mem_rvalid ignored in ADDR.
- DATA: mem_req=0, mem_we=0. On mem_rvalid -> IDLE; next cycle wb_valid=1 for one cycle with wb_rd=latched rd, wb_we=latched read, wb_data aligned (stores: wb_data=0).
- Minimum latency: accept cycle N, mem_req N+1, gnt N+1, rvalid N+2, wb_valid N+3. New request accepted the cycle wb_valid pulses (back-to-back).
- Alignment (lane=addr[1:0]): LB sign-extends rdata[8*lane+7:8*lane]; LBU zero-extends; LH/LHU take rdata[31:16] if addr[1] else [15:0], sign/zero-extended; LW whole word.
- Timeout: counter clears on accept, increments each cycle in ADDR or DATA; reaching TIMEOUT_CYCLES without completion -> bus_error pulse one cycle, wb_valid stays 0, state IDLE. Completion on the terminal cycle wins over timeout.
- Counter saturates; never wraps.

Optional Feature:
MISALIGNED_TRAP_EN. Defined: at accept, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no bus transaction; misaligned pulses one cycle later, FSM stays IDLE, no wb_valid. Undefined: misaligned tied 0; addr[1:0] used only for lane selection, word accesses ignore them.

Test Plan:
- LB addr 0x103, rdata 0x80FF_0000, gnt/rvalid immediate -> wb_valid at N+3, wb_data 0xFFFF_FF80, wb_we=1.
- LHU addr 0x102, rdata 0x8001_1234 -> wb_data 0x0000_8001; LH same -> 0xFFFF_8001.
- SW addr 0x200, wdata 0xDEAD_BEEF, gnt delayed 3 cycles -> mem_req/mem_addr/mem_we=1111 stable all 4 ADDR cycles, stall=1 throughout, wb_valid with wb_we=0.
- TIMEOUT_CYCLES=16, gnt given, rvalid never -> bus_error one pulse 16 cycles after accept, no wb_valid, req_ready=1 next cycle.
- reset_n low while in DATA, then rvalid -> outputs reset immediately, no wb_valid after release.
- With MISALIGNED_TRAP_EN, LW addr 0x101 -> mem_req never asserts, misaligned pulses at N+1.
